// File: rtl/maq_pkg.sv
// Shared types and standard count ranges for the BCD counter stages.
// Latency: n/a (types, constants and a pure conversion helper only).
// Backpressure: n/a.
package maq_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Inclusive decimal count range of one counter stage.
    typedef struct packed {
        logic [7:0] min_val;
        logic [7:0] max_val;
    } bcd_range_t;

    localparam bcd_range_t MINUTO = '{min_val: 8'd0, max_val: 8'd59};
    localparam bcd_range_t HORA24 = '{min_val: 8'd0, max_val: 8'd23};
    localparam bcd_range_t HORA12 = '{min_val: 8'd1, max_val: 8'd12};

    // Decimal value of a tens/units digit pair; the tens digit is passed
    // zero-extended to a full nibble so one helper serves any MSD_W.
    function automatic int bcd_to_bin(input bcd_digit_t msd, input bcd_digit_t lsd);
        return 10 * int'(msd) + int'(lsd);
    endfunction

endpackage

// File: rtl/maq_bcd_passo.sv
// Combinational BCD +1/-1 step of a tens/units digit pair within [MIN_VAL, MAX_VAL].
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the step result is used.
// Ports: msd/lsd current digits, up selects +1 (1) or -1 (0),
//        nxt_msd/nxt_lsd stepped digits, wrap flags MAX->MIN (up) or MIN->MAX (down).
module maq_bcd_passo
    import maq_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59,
    parameter int MSD_W   = 3
) (
    input  logic [MSD_W-1:0] msd,
    input  bcd_digit_t       lsd,
    input  logic             up,
    output logic [MSD_W-1:0] nxt_msd,
    output bcd_digit_t       nxt_lsd,
    output logic             wrap
);

    localparam logic [MSD_W-1:0] MIN_MSD = MSD_W'(MIN_VAL / 10);
    localparam bcd_digit_t       MIN_LSD = 4'(MIN_VAL % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'(MAX_VAL / 10);
    localparam bcd_digit_t       MAX_LSD = 4'(MAX_VAL % 10);

    logic at_min;
    logic at_max;

    assign at_min = (msd == MIN_MSD) && (lsd == MIN_LSD);
    assign at_max = (msd == MAX_MSD) && (lsd == MAX_LSD);

    always_comb begin
        nxt_msd = msd;
        nxt_lsd = lsd;
        wrap    = 1'b0;
        if (up) begin
            if (at_max) begin
                nxt_msd = MIN_MSD;
                nxt_lsd = MIN_LSD;
                wrap    = 1'b1;
            end else if (lsd == 4'd9) begin
                // Units roll over into the tens digit.
                nxt_lsd = 4'd0;
                nxt_msd = msd + 1'b1;
            end else begin
                nxt_lsd = lsd + 4'd1;
            end
        end else begin
            if (at_min) begin
                nxt_msd = MAX_MSD;
                nxt_lsd = MAX_LSD;
                wrap    = 1'b1;
            end else if (lsd == 4'd0) begin
                // Units borrow from the tens digit.
                nxt_lsd = 4'd9;
                nxt_msd = msd - 1'b1;
            end else begin
                nxt_lsd = lsd - 4'd1;
            end
        end
    end

endmodule

// File: rtl/maq_bcd_generico.sv
// Generic two-digit BCD up/down counter stage with preset, carry/borrow chaining.
// Latency: digits and carry/borrow/load_err pulses update one clock after the sampling edge.
// Backpressure: none; counting is qualified by the 1 Hz enable, preset acts on any clock.
// Ports: clock/reset (async, active-high), enable1hz count qualifier, inc/dec requests,
//        load + load_lsd/load_msd preset, bcd_lsd/bcd_msd registered digits,
//        carry/borrow single-clock wrap pulses, load_err single-clock rejected-preset pulse.
module maq_bcd_generico
    import maq_pkg::*;
#(
    parameter int MIN_VAL = int'(MINUTO.min_val),
    parameter int MAX_VAL = int'(MINUTO.max_val),
    parameter int RST_VAL = int'(MINUTO.min_val),
    parameter int MSD_W   = 3
) (
    input  logic             maq_bcd_generico_clock,
    input  logic             maq_bcd_generico_reset,
    input  logic             maq_bcd_generico_enable1hz,
    input  logic             maq_bcd_generico_inc,
    input  logic             maq_bcd_generico_dec,
    input  logic             maq_bcd_generico_load,
    input  bcd_digit_t       maq_bcd_generico_load_lsd,
    input  logic [MSD_W-1:0] maq_bcd_generico_load_msd,
    output bcd_digit_t       maq_bcd_generico_bcd_lsd,
    output logic [MSD_W-1:0] maq_bcd_generico_bcd_msd,
    output logic             maq_bcd_generico_carry,
    output logic             maq_bcd_generico_borrow,
    output logic             maq_bcd_generico_load_err
);

    // Largest value representable with a 0..9 units digit and MSD_W tens bits.
    localparam int VAL_CEIL = 10 * (1 << MSD_W) - 1;

    if ((MSD_W < 1) || (MSD_W > 4) ||
        (MIN_VAL < 0) || (MIN_VAL >= MAX_VAL) || (MAX_VAL > VAL_CEIL) ||
        (RST_VAL < MIN_VAL) || (RST_VAL > MAX_VAL)) begin : g_bad_params
        $fatal(1, "maq_bcd_generico: illegal MIN_VAL/MAX_VAL/RST_VAL/MSD_W combination");
    end

    localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RST_VAL / 10);
    localparam bcd_digit_t       RST_LSD = 4'(RST_VAL % 10);

    logic [MSD_W-1:0] msd_q;
    bcd_digit_t       lsd_q;
    logic             carry_q;
    logic             borrow_q;
    logic             load_err_q;

    logic [MSD_W-1:0] step_msd;
    bcd_digit_t       step_lsd;
    logic             step_wrap;

    int               load_val;
    logic             load_ok;
    logic             count_en;

    maq_bcd_passo #(
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .MSD_W   (MSD_W)
    ) u_passo (
        .msd     (msd_q),
        .lsd     (lsd_q),
        .up      (maq_bcd_generico_inc),
        .nxt_msd (step_msd),
        .nxt_lsd (step_lsd),
        .wrap    (step_wrap)
    );

    // A preset is legal only with a decimal units digit and a value inside the range.
    assign load_val = bcd_to_bin(bcd_digit_t'(maq_bcd_generico_load_msd), maq_bcd_generico_load_lsd);
    assign load_ok  = (int'(maq_bcd_generico_load_lsd) <= 9) &&
                      (load_val >= MIN_VAL) && (load_val <= MAX_VAL);

    // inc and dec together cancel out; a load in the same cycle wins outright.
    assign count_en = maq_bcd_generico_enable1hz && !maq_bcd_generico_load &&
                      (maq_bcd_generico_inc ^ maq_bcd_generico_dec);

    always_ff @(posedge maq_bcd_generico_clock or posedge maq_bcd_generico_reset) begin
        if (maq_bcd_generico_reset) begin
            msd_q      <= RST_MSD;
            lsd_q      <= RST_LSD;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
            if (maq_bcd_generico_load) begin
                if (load_ok) begin
                    msd_q <= maq_bcd_generico_load_msd;
                    lsd_q <= maq_bcd_generico_load_lsd;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (count_en) begin
                msd_q    <= step_msd;
                lsd_q    <= step_lsd;
                carry_q  <= step_wrap && maq_bcd_generico_inc;
                borrow_q <= step_wrap && maq_bcd_generico_dec;
            end
        end
    end

    assign maq_bcd_generico_bcd_msd  = msd_q;
    assign maq_bcd_generico_bcd_lsd  = lsd_q;
    assign maq_bcd_generico_carry    = carry_q;
    assign maq_bcd_generico_borrow   = borrow_q;
    assign maq_bcd_generico_load_err = load_err_q;

endmodule

// File: doc/maq_bcd_generico.md
MAQ_BCD_GENERICO -- requirements
Module: maq_bcd_generico

Interface
REQ-001 Parameter MIN_VAL, default 0: lowest count value, decimal.
REQ-002 Parameter MAX_VAL, default 59: highest count value, decimal.
REQ-003 Parameter RST_VAL, default 0: value loaded at reset, decimal.
REQ-004 Parameter MSD_W, default 3: tens-digit width in bits.
REQ-005 maq_bcd_generico_clock  input  1  single clock, rising-edge.
REQ-006 maq_bcd_generico_reset  input  1  asynchronous, active-high reset.
REQ-007 maq_bcd_generico_enable1hz  input  1  count qualifier, one-clock pulse per second.
REQ-008 maq_bcd_generico_inc  input  1  increment request, sampled only with enable1hz.
REQ-009 maq_bcd_generico_dec  input  1  decrement request, sampled only with enable1hz.
REQ-010 maq_bcd_generico_load  input  1  synchronous preset strobe; not gated by enable1hz.
REQ-011 maq_bcd_generico_load_lsd  input  4  preset units digit.
REQ-012 maq_bcd_generico_load_msd  input  MSD_W  preset tens digit.
REQ-013 maq_bcd_generico_bcd_lsd  output  4  units digit, registered.
REQ-014 maq_bcd_generico_bcd_msd  output  MSD_W  tens digit, registered.
REQ-015 maq_bcd_generico_carry  output  1  wrap-up pulse to next stage, registered.
REQ-016 maq_bcd_generico_borrow  output  1  wrap-down pulse to next stage, registered.
REQ-017 maq_bcd_generico_load_err  output  1  rejected-preset pulse, registered.

Function
REQ-018 Value V = 10*msd + lsd; V always stays in [MIN_VAL, MAX_VAL] and lsd always stays in 0..9.
REQ-019 Priority per clock: load > count > hold.
REQ-020 Load with legal value (lsd<=9, MIN_VAL<=V<=MAX_VAL): digits take the preset on that edge, with no carry/borrow.
REQ-021 Load with illegal value: digits unchanged, load_err=1 for exactly one clock, no count that cycle.
REQ-022 Count occurs only when enable1hz=1, load=0 and exactly one of inc/dec=1.
REQ-023 Increment, V<MAX_VAL: lsd<9 gives lsd+1; lsd=9 gives lsd=0, msd+1.
REQ-024 Increment, V=MAX_VAL: V becomes MIN_VAL and carry=1 for exactly one clock.
REQ-025 Decrement, V>MIN_VAL: lsd>0 gives lsd-1; lsd=0 gives lsd=9, msd-1.
REQ-026 Decrement, V=MIN_VAL: V becomes MAX_VAL and borrow=1 for exactly one clock.
REQ-027 inc=dec=1 with enable1hz: hold, no pulses.
REQ-028 enable1hz=0: inc/dec ignored, digits hold.
REQ-029 carry, borrow and load_err are zero in every cycle without their triggering event.
REQ-030 Latency: digit and pulse updates are visible one clock after the sampling edge.
REQ-031 Parameter legality is checked at elaboration: 0<=MIN_VAL<MAX_VAL<=10*2^MSD_W-1, MIN_VAL<=RST_VAL<=MAX_VAL, MSD_W in 1..4; violation is a fatal error.

Reset
REQ-032 Reset asserted, independent of clock: digits = RST_VAL, carry=borrow=load_err=0.
REQ-033 Reset asserted mid-operation aborts any pending load/count; no pulse is emitted on or after release.
REQ-034 The first count or load is accepted on the first rising edge with reset low.

Structure
REQ-035 Package maq_pkg holds typedef bcd_digit_t (4 bits) and the configuration constants MINUTO (0..59), HORA24 (0..23) and HORA12 (1..12).
REQ-036 One combinational sub-module, maq_bcd_passo, computes the BCD +1/-1 of a digit pair and flags the wrap; the state register stays in maq_bcd_generico.

Verification
REQ-037 Default params, reset then 60 enable pulses with inc=1: 00..59 then 00, carry high only in the single cycle after 59->00.
REQ-038 MIN=1, MAX=12, V=01, enable with dec=1: V=12 and borrow pulses once; next inc: V=01 and carry pulses once.
REQ-039 Load lsd=9, msd=6 (69>59): digits unchanged, load_err=1 one cycle; load 4/5: V=45 next clock.
REQ-040 load=1, enable1hz=1, inc=1 all together at V=59: V=preset, no carry.
REQ-041 inc=dec=1 with enable1hz, and inc=1 with enable1hz=0: V unchanged, no pulses.
REQ-042 Reset asserted between clock edges while a carry is pending: outputs go to RST_VAL/0 immediately, no carry after release.
